// File: rtl/atm_keypad_entry_pkg.sv
// rtl/atm_keypad_entry_pkg.sv - shared definitions for the ATM keypad entry front end
package atm_keypad_entry_pkg;

  // Operation codes presented to the ATM controller
  localparam logic [2:0] OP_NONE       = 3'd0;
  localparam logic [2:0] OP_BALANCE    = 3'd1;
  localparam logic [2:0] OP_WITHDRAW   = 3'd2;
  localparam logic [2:0] OP_DEPOSIT    = 3'd3;
  localparam logic [2:0] OP_CHANGE_PIN = 3'd4;

  // Non-digit key codes; 0xD-0xF are reserved and carry no meaning
  localparam logic [3:0] KEY_ENTER  = 4'hA;
  localparam logic [3:0] KEY_CLEAR  = 4'hB;
  localparam logic [3:0] KEY_CANCEL = 4'hC;

  // Operation menu: digit pressed in OP selects the operation
  localparam logic [3:0] MENU_BALANCE    = 4'd1;
  localparam logic [3:0] MENU_WITHDRAW   = 4'd2;
  localparam logic [3:0] MENU_DEPOSIT    = 4'd3;
  localparam logic [3:0] MENU_CHANGE_PIN = 4'd4;

  // Field length limits
  localparam logic [3:0] PIN_DIGITS     = 4'd4;
  localparam logic [3:0] AMT_MAX_DIGITS = 4'd9;

  // Entry state encodings, also exported on entry_state
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACC    = 3'd1,
    ST_PIN    = 3'd2,
    ST_OP     = 3'd3,
    ST_AMT    = 3'd4,
    ST_NEWPIN = 3'd5,
    ST_ISSUE  = 3'd6
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/atm_keypad_entry_timeout.sv
// rtl/atm_keypad_entry_timeout.sv - inactivity counter that flags the cycle before it reaches its limit
module entry_timeout #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // expired is raised while the count sits one below the limit, so the
  // owner acts on the very edge at which the count would reach TIMEOUT_CYCLES-1
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

  logic [CW-1:0] cnt;

  // Count enabled idle cycles; any clear or disable restarts from zero
  always_ff @(posedge clk) begin
    if (rst || clear || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/atm_keypad_entry.sv
// rtl/atm_keypad_entry.sv - keypad entry FSM assembling an ATM transaction request
module atm_keypad_entry
  import atm_keypad_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        req_ready,
  output logic        req_valid,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] new_pin,
  output logic [2:0]  operation,
  output logic [31:0] amount,
  output logic [3:0]  digit_count,
  output logic [2:0]  entry_state,
  output logic        abort,
  output logic        timeout_err
);

  entry_state_e state_q, state_d;
  logic [3:0]   acc_d;
  logic [15:0]  pin_d, new_pin_d;
  logic [2:0]   op_d;
  logic [31:0]  amt_d;
  logic [3:0]   cnt_d;
  logic         abort_d, tmo_d, clear_all;
  logic         k_digit, k_enter, k_clear, k_cancel;
  logic         active_q, active_d, tmo_expired;

  assign k_digit  = key_valid && is_digit(key_code);
  assign k_enter  = key_valid && (key_code == KEY_ENTER);
  assign k_clear  = key_valid && (key_code == KEY_CLEAR);
  assign k_cancel = key_valid && (key_code == KEY_CANCEL);

  // Entry states are the ones where CANCEL and the inactivity timer apply
  assign active_q = (state_q != ST_IDLE) && (state_q != ST_ISSUE);
  assign active_d = (state_d != ST_IDLE) && (state_d != ST_ISSUE);

  // Any key restarts the timer; leaving the entry states parks it at zero
  entry_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (key_valid || !active_d),
    .enable (active_q),
    .expired(tmo_expired)
  );

  // Next-state and field updates; CANCEL beats expiry, any key beats expiry
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_num;
    pin_d     = pin;
    new_pin_d = new_pin;
    op_d      = operation;
    amt_d     = amount;
    cnt_d     = digit_count;
    abort_d   = 1'b0;
    tmo_d     = 1'b0;
    clear_all = 1'b0;

    if (active_q && k_cancel) begin
      state_d   = ST_IDLE;
      clear_all = 1'b1;
      abort_d   = 1'b1;
    end else if (active_q && !key_valid && tmo_expired) begin
      state_d   = ST_IDLE;
      clear_all = 1'b1;
      abort_d   = 1'b1;
      tmo_d     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (k_digit) begin
            acc_d   = key_code;
            cnt_d   = 4'd1;
            state_d = ST_ACC;
          end
        end
        // digit_count doubles as the account-captured flag here
        ST_ACC: begin
          if (k_digit) begin
            acc_d = key_code;
            cnt_d = 4'd1;
          end else if (k_clear) begin
            cnt_d = 4'd0;
          end else if (k_enter && (digit_count != 4'd0)) begin
            cnt_d   = 4'd0;
            state_d = ST_PIN;
          end
        end
        ST_PIN: begin
          if (k_digit && (digit_count < PIN_DIGITS)) begin
            pin_d = {pin[11:0], key_code};
            cnt_d = digit_count + 4'd1;
          end else if (k_clear) begin
            pin_d = '0;
            cnt_d = 4'd0;
          end else if (k_enter && (digit_count == PIN_DIGITS)) begin
            cnt_d   = 4'd0;
            state_d = ST_OP;
          end
        end
        ST_OP: begin
          if (k_digit) begin
            case (key_code)
              MENU_BALANCE: begin
                op_d    = OP_BALANCE;
                state_d = ST_ISSUE;
              end
              MENU_WITHDRAW: begin
                op_d    = OP_WITHDRAW;
                state_d = ST_AMT;
              end
              MENU_DEPOSIT: begin
                op_d    = OP_DEPOSIT;
                state_d = ST_AMT;
              end
              MENU_CHANGE_PIN: begin
                op_d    = OP_CHANGE_PIN;
                state_d = ST_NEWPIN;
              end
              default: ;
            endcase
          end
        end
        // Nine decimal digits always fit in 32 bits, so no overflow check
        ST_AMT: begin
          if (k_digit && (digit_count < AMT_MAX_DIGITS)) begin
            amt_d = (amount << 3) + (amount << 1) + {28'd0, key_code};
            cnt_d = digit_count + 4'd1;
          end else if (k_clear) begin
            amt_d = '0;
            cnt_d = 4'd0;
          end else if (k_enter && (digit_count != 4'd0)) begin
            state_d = ST_ISSUE;
          end
        end
        ST_NEWPIN: begin
          if (k_digit && (digit_count < PIN_DIGITS)) begin
            new_pin_d = {new_pin[11:0], key_code};
            cnt_d     = digit_count + 4'd1;
          end else if (k_clear) begin
            new_pin_d = '0;
            cnt_d     = 4'd0;
          end else if (k_enter && (digit_count == PIN_DIGITS)) begin
            state_d = ST_ISSUE;
          end
        end
        // Request is never withdrawn: only the handshake leaves ISSUE
        ST_ISSUE: begin
          if (req_valid && req_ready) begin
            state_d   = ST_IDLE;
            clear_all = 1'b1;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          clear_all = 1'b1;
        end
      endcase
    end

    if (clear_all) begin
      acc_d     = '0;
      pin_d     = '0;
      new_pin_d = '0;
      op_d      = OP_NONE;
      amt_d     = '0;
      cnt_d     = '0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_valid   <= 1'b0;
      acc_num     <= '0;
      pin         <= '0;
      new_pin     <= '0;
      operation   <= OP_NONE;
      amount      <= '0;
      digit_count <= '0;
      abort       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid   <= (state_d == ST_ISSUE);
      acc_num     <= acc_d;
      pin         <= pin_d;
      new_pin     <= new_pin_d;
      operation   <= op_d;
      amount      <= amt_d;
      digit_count <= cnt_d;
      abort       <= abort_d;
      timeout_err <= tmo_d;
    end
  end

  assign entry_state = state_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb/tb_atm_keypad_entry.sv - scoreboard bench for atm_keypad_entry
module tb_atm_keypad_entry;
  import atm_keypad_entry_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        req_ready = 1'b0;
  logic        req_valid;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic [15:0] new_pin;
  logic [2:0]  operation;
  logic [31:0] amount;
  logic [3:0]  digit_count;
  logic [2:0]  entry_state;
  logic        abort;
  logic        timeout_err;

  atm_keypad_entry #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .req_ready  (req_ready),
    .req_valid  (req_valid),
    .acc_num    (acc_num),
    .pin        (pin),
    .new_pin    (new_pin),
    .operation  (operation),
    .amount     (amount),
    .digit_count(digit_count),
    .entry_state(entry_state),
    .abort      (abort),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  acc;
    logic [15:0] pin;
    logic [15:0] new_pin;
    logic [2:0]  op;
    logic [31:0] amount;
  } req_t;

  req_t exp_req[$];
  bit   exp_abort[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 1'b0;

  // Reference model: phase plus the digits typed so far in each field
  entry_state_e m_phase = ST_IDLE;
  int           m_acc;
  bit           m_have;
  int           m_pin[$];
  int           m_npin[$];
  int           m_amt[$];
  logic [2:0]   m_op;
  int           m_idle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_have = 1'b0;
    m_pin.delete();
    m_npin.delete();
    m_amt.delete();
    m_op = OP_NONE;
    m_idle = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_phase = ST_IDLE;
    exp_req.delete();
    exp_abort.delete();
  endtask

  task automatic model_issue();
    req_t   r;
    int     p, np;
    longint a;
    p = 0; np = 0; a = 0;
    foreach (m_pin[i]) p = p * 16 + m_pin[i];
    foreach (m_npin[i]) np = np * 16 + m_npin[i];
    foreach (m_amt[i]) a = a * 10 + m_amt[i];
    r.acc = m_acc[3:0];
    r.pin = p[15:0];
    r.new_pin = np[15:0];
    r.op = m_op;
    r.amount = a[31:0];
    exp_req.push_back(r);
    m_phase = ST_ISSUE;
  endtask

  task automatic model_step(input bit kv, input logic [3:0] kc, input bit rdy);
    bit dig;
    dig = kv && (kc <= 4'd9);
    if (m_phase == ST_ISSUE) begin
      if (rdy) begin
        model_clear();
        m_phase = ST_IDLE;
      end
    end else if (m_phase == ST_IDLE) begin
      if (dig) begin
        model_clear();
        m_acc = int'(kc);
        m_have = 1'b1;
        m_phase = ST_ACC;
      end
    end else if (!kv) begin
      m_idle++;
      if (m_idle == TO - 1) begin
        exp_abort.push_back(1'b1);
        model_clear();
        m_phase = ST_IDLE;
      end
    end else if (kc == 4'hC) begin
      exp_abort.push_back(1'b0);
      model_clear();
      m_phase = ST_IDLE;
    end else begin
      m_idle = 0;
      case (m_phase)
        ST_ACC: begin
          if (dig) begin m_acc = int'(kc); m_have = 1'b1; end
          else if (kc == 4'hB) m_have = 1'b0;
          else if (kc == 4'hA && m_have) m_phase = ST_PIN;
        end
        ST_PIN: begin
          if (dig) begin if (m_pin.size() < 4) m_pin.push_back(int'(kc)); end
          else if (kc == 4'hB) m_pin.delete();
          else if (kc == 4'hA && m_pin.size() == 4) m_phase = ST_OP;
        end
        ST_OP: begin
          if (kc == 4'd1) begin m_op = OP_BALANCE; model_issue(); end
          else if (kc == 4'd2) begin m_op = OP_WITHDRAW; m_phase = ST_AMT; end
          else if (kc == 4'd3) begin m_op = OP_DEPOSIT; m_phase = ST_AMT; end
          else if (kc == 4'd4) begin m_op = OP_CHANGE_PIN; m_phase = ST_NEWPIN; end
        end
        ST_AMT: begin
          if (dig) begin if (m_amt.size() < 9) m_amt.push_back(int'(kc)); end
          else if (kc == 4'hB) m_amt.delete();
          else if (kc == 4'hA && m_amt.size() >= 1) model_issue();
        end
        ST_NEWPIN: begin
          if (dig) begin if (m_npin.size() < 4) m_npin.push_back(int'(kc)); end
          else if (kc == 4'hB) m_npin.delete();
          else if (kc == 4'hA && m_npin.size() == 4) model_issue();
        end
        default: ;
      endcase
    end
  endtask

  task automatic cycle(input bit kv, input logic [3:0] kc);
    key_valid = kv;
    key_code = kc;
    @(posedge clk);
    model_step(kv, kc, req_ready);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'd0);
  endtask

  task automatic keys(input string s);
    byte c;
    logic [3:0] k;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      if (c >= "0" && c <= "9") k = 4'(c - "0");
      else k = 4'(c - "A" + 10);
      cycle(1'b1, k);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_acc"}, acc_num, 0);
    check({tag, "_pin"}, pin, 0);
    check({tag, "_new_pin"}, new_pin, 0);
    check({tag, "_op"}, operation, 0);
    check({tag, "_amount"}, amount, 0);
    check({tag, "_count"}, digit_count, 0);
    check({tag, "_state"}, entry_state, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_tmo"}, timeout_err, 0);
  endtask

  // Monitor: compares DUT outputs with the model and the expected queues
  always @(negedge clk) begin
    req_t r;
    if (started && !rst) begin
      check("state", entry_state, m_phase);
      check("req_valid", req_valid, m_phase == ST_ISSUE);
      if (m_phase == ST_PIN) check("pin_count", digit_count, m_pin.size());
      if (m_phase == ST_AMT) check("amt_count", digit_count, m_amt.size());
      if (m_phase == ST_NEWPIN) check("newpin_count", digit_count, m_npin.size());
      if (m_phase == ST_IDLE)
        check("idle_fields", {acc_num, pin, new_pin, operation, amount}, 0);
      if (abort) begin
        if (exp_abort.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_abort actual=1 required=0");
        end else begin
          check("timeout_err", timeout_err, exp_abort.pop_front());
        end
      end else begin
        check("timeout_err_quiet", timeout_err, 0);
      end
      if (exp_abort.size() != 0) begin
        total++; bad++;
        $display("FAIL missing_abort actual=0 required=1");
        exp_abort.delete();
      end
      if (req_valid) begin
        if (exp_req.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_request actual=1 required=0");
        end else begin
          r = exp_req[0];
          check("req_acc", acc_num, r.acc);
          check("req_pin", pin, r.pin);
          check("req_new_pin", new_pin, r.new_pin);
          check("req_op", operation, r.op);
          check("req_amount", amount, r.amount);
          if (req_ready) void'(exp_req.pop_front());
        end
      end
    end
  end

  initial begin
    int r;
    bit kv;
    logic [3:0] kc;

    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    model_reset();
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    started = 1'b1;

    // Balance
    req_ready = 1'b1;
    keys("3A1234A1");
    check("bal_valid", req_valid, 1);
    check("bal_op", operation, OP_BALANCE);
    idle(1);
    check("bal_done", req_valid, 0);
    idle(1);

    // Withdraw with back-pressure
    req_ready = 1'b0;
    keys("7A9876A2500A");
    idle(5);
    check("wd_amount", amount, 500);
    check("wd_pin", pin, 16'h9876);
    req_ready = 1'b1;
    idle(1);
    check("wd_cleared", req_valid, 0);

    // Field limits
    keys("1A12345");
    check("pin_limit", pin, 16'h1234);
    check("pin_limit_count", digit_count, 4);
    keys("A2");
    keys("9999999999");
    check("amt_limit", amount, 999999999);
    keys("A");
    idle(2);

    // PIN editing and change-PIN path
    keys("2A123A");
    check("short_enter", entry_state, ST_PIN);
    keys("B");
    check("clear_pin", pin, 0);
    check("clear_count", digit_count, 0);
    keys("5678A4");
    keys("5555A");
    check("newpin", new_pin, 16'h5555);
    idle(2);

    // CANCEL in AMT
    keys("1A1111A212C");
    check("cancel_abort", abort, 1);
    check("cancel_tmo", timeout_err, 0);
    check("cancel_amount", amount, 0);
    idle(1);

    // Timeout in PIN
    keys("1A");
    idle(6);
    check("tmo_early", abort, 0);
    idle(1);
    check("tmo_abort", abort, 1);
    check("tmo_flag", timeout_err, 1);
    idle(1);

    // Key on the expiry cycle, then CANCEL on the expiry cycle
    keys("1A");
    idle(6);
    keys("1");
    check("key_wins", abort, 0);
    check("key_wins_state", entry_state, ST_PIN);
    idle(6);
    keys("C");
    check("cancel_vs_tmo", abort, 1);
    check("cancel_vs_tmo_flag", timeout_err, 0);
    idle(1);

    // CANCEL ignored in ISSUE, then reset in ISSUE
    req_ready = 1'b0;
    keys("4A4321A1");
    keys("C");
    check("issue_cancel_state", entry_state, ST_ISSUE);
    check("issue_cancel_abort", abort, 0);
    rst = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_all_zero("issue_reset");
    rst = 1'b0;
    idle(1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 40) == 0) idle(9);
      req_ready = 1'($urandom_range(0, 1));
      kv = ($urandom_range(0, 9) < 7);
      r = int'($urandom_range(0, 99));
      if (r < 60) kc = 4'($urandom_range(0, 9));
      else if (r < 80) kc = KEY_ENTER;
      else if (r < 85) kc = KEY_CLEAR;
      else if (r < 88) kc = KEY_CANCEL;
      else kc = 4'($urandom_range(13, 15));
      cycle(kv, kc);
    end

    req_ready = 1'b1;
    idle(3);
    check("drain_req", exp_req.size(), 0);
    check("drain_abort", exp_abort.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/atm_keypad_entry.md
# atm_keypad_entry

Keypad front end that sits directly upstream of the ATM controller. Collects single-cycle key strobes and assembles a complete transaction request: account digit, 4-digit BCD PIN, operation, and either a decimal amount or a new PIN. Presents the request to the ATM over a valid/ready handshake. Aborts on CANCEL or inactivity timeout.

## Interface

**Parameters**
- `TIMEOUT_CYCLES`, default 1000: cycles without an accepted key before the entry is aborted (≥2).

**Ports**
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous reset, active-high.
- `key_valid`  in  1: one-cycle strobe, key present. Back-to-back strobes are legal.
- `key_code`  in  4: 0x0–0x9 digit; 0xA ENTER; 0xB CLEAR; 0xC CANCEL; 0xD–0xF reserved (ignored).
- `req_ready`  in  1: ATM accepts the request.
- `req_valid`  out  1: request fields are valid and stable.
- `acc_num`  out  4: account digit, 0–9.
- `pin`  out  16: 4 BCD digits, first-entered digit in [15:12].
- `new_pin`  out  16: same format as `pin`; zero unless the operation is CHANGE_PIN.
- `operation`  out  3: `BALANCE`, `WITHDRAW`, `DEPOSIT` or `CHANGE_PIN` code from the shared definitions.
- `amount`  out  32: unsigned binary amount; zero for BALANCE and CHANGE_PIN.
- `digit_count`  out  4: digits held in the current field, for the display.
- `entry_state`  out  3: current state encoding.
- `abort`  out  1: one-cycle pulse when an entry is cancelled or times out.
- `timeout_err`  out  1: qualifies `abort`; 1 means the abort was caused by timeout.

## Operation

States: IDLE, ACC, PIN, OP, AMT, NEWPIN, ISSUE.

- **IDLE**
  - A digit key loads `acc_num` and moves to ACC.
  - Other keys are ignored.
- **ACC**
  - A digit overwrites `acc_num`.
  - CLEAR clears the account-captured flag; the next digit is then required.
  - ENTER with an account captured moves to PIN and resets `digit_count`.
- **PIN**
  - A digit shifts in: `pin <= {pin[11:0], d}`, and `digit_count` increments.
  - A 5th and later digit is ignored.
  - CLEAR zeroes `pin` and `digit_count`.
  - ENTER with count==4 moves to OP; ENTER with count<4 is ignored.
- **OP**
  - Digit 1 selects BALANCE and moves to ISSUE.
  - Digit 2 selects WITHDRAW and moves to AMT.
  - Digit 3 selects DEPOSIT and moves to AMT.
  - Digit 4 selects CHANGE_PIN and moves to NEWPIN.
  - Other digits, ENTER and CLEAR are ignored.
- **AMT**
  - A digit updates `amount <= amount*10 + d`, computed as `(amount<<3)+(amount<<1)+d` in 32 bits.
  - Maximum 9 digits (999 999 999 < 2^32, so no overflow); a 10th digit is ignored.
  - CLEAR zeroes `amount` and the count.
  - ENTER with count≥1 moves to ISSUE.
- **NEWPIN**
  - Identical to PIN, but writes `new_pin`.
  - ENTER with count==4 moves to ISSUE.
- **ISSUE**
  - `req_valid` is held at 1 with all fields frozen.
  - On `req_valid && req_ready`, go to IDLE and clear all fields.
  - All keys, including CANCEL, are ignored: a request is never retracted once offered.
  - No timeout applies in ISSUE.
- **CANCEL**
  - In ACC, PIN, OP, AMT or NEWPIN: go to IDLE, clear all fields, pulse `abort` with `timeout_err`=0.
- **Timeout**
  - The inactivity counter runs in ACC through NEWPIN.
  - It is reset by every accepted `key_valid`, including ignored-content keys, and on entry to ACC.
  - Reaching `TIMEOUT_CYCLES-1` goes to IDLE, clears all fields, and pulses `abort` with `timeout_err`=1.

## Timing

- All outputs are registered.
- Reset values: every output is 0; state is IDLE; the counter is 0.
- A key is consumed on the edge where `key_valid`=1; the resulting field and state updates are visible the next cycle.
- `req_valid` rises the cycle after the final accepted ENTER (or OP digit 1).
- The handshake completes on the edge with both signals high; `req_valid` is 0 the following cycle. Minimum request turnaround is 1 cycle.
- A key arriving in the same cycle as counter expiry: the key wins, the counter resets, and no abort occurs.
- CANCEL and expiry in the same cycle: `abort` with `timeout_err`=0.
- `rst` mid-entry or mid-ISSUE clears everything at the next edge, with no `abort` pulse and no request.
- `timeout_err` is only meaningful while `abort`=1; it is 0 otherwise.

## Structure

- Add to the shared definitions file:
  - key-code constants (KEY_ENTER, KEY_CLEAR, KEY_CANCEL);
  - the entry-state encodings;
  - the OP-menu digit mapping.
- Operation codes are reused from the existing definitions, not redefined.
- One sub-module, `entry_timeout`: a parameterised inactivity counter with `clear` and `enable` inputs and an `expired` output. The FSM and field registers stay in `atm_keypad_entry`.

## Test plan

- **Balance:** keys 3,ENTER,1,2,3,4,ENTER,1 with `req_ready`=1 → `req_valid`=1 for one cycle; acc_num=3, pin=16'h1234, operation=`BALANCE`, amount=0.
- **Withdraw with back-pressure:** keys 7,ENTER,9,8,7,6,ENTER,2,5,0,0,ENTER; `req_ready` low for 5 cycles → amount=500 and pin=16'h9876 held stable while valid; request cleared the cycle after ready.
- **Field limits:** digits 1–5 in PIN → pin=16'h1234, count=4. Ten 9s in AMT → amount=999999999.
- **PIN editing:** ENTER with only 3 PIN digits → stays in PIN. CLEAR → pin=0, count=0. CHANGE_PIN path with 5,5,5,5 → new_pin=16'h5555.
- **Abort paths:**
  - CANCEL in AMT → `abort`=1, `timeout_err`=0, all fields 0, state IDLE.
  - With TIMEOUT_CYCLES=8 and no keys in PIN → `abort` plus `timeout_err` after the 7th idle cycle.
  - A key on the expiry cycle → no abort.
- **Reset and ISSUE:** CANCEL while in ISSUE → ignored. `rst` pulse in ISSUE → all outputs 0, no `abort`.
